// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: opcodes, FSM states
// and the opcode-class helper used by the load-use compare.
package pipeline_stall_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    // Instructions that read rt as a source (R-type, beq, sw store data).
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the lw in EX and the
// instruction in ID.
module hazard_detect
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic [5:0] ifid_op_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rt_i,
    output logic       stall_o
);

    always_comb begin
        stall_o = idex_memread_i && (idex_rt_i != 5'd0) &&
                  ((idex_rt_i == ifid_rs_i) ||
                   (uses_rt(ifid_op_i) && (idex_rt_i == ifid_rt_i)));
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencer: FSM, memory wait counter and stall/flush performance
// counters; all pipeline-register enables are combinational from state and inputs.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 200,
    parameter int CNT_W       = 8,
    parameter int PERF_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [5:0]        ifid_op_i,
    input  logic [4:0]        ifid_rs_i,
    input  logic [4:0]        ifid_rt_i,
    input  logic              idex_memread_i,
    input  logic [4:0]        idex_rt_i,
    input  logic              branch_taken_i,
    input  logic              jump_i,
    input  logic              exmem_memread_i,
    input  logic              exmem_memwrite_i,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_write_o,
    output logic              idex_bubble_o,
    output logic              exmem_write_o,
    output logic              memwb_bubble_o,
    output logic              mem_timeout_o,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic                timeout_q, timeout_d;
    logic [PERF_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mem_access;
    logic freeze;
    logic advance;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_detect u_hazard_detect (
        .ifid_op_i      (ifid_op_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .stall_o        (load_use)
    );

    assign mem_access = exmem_memread_i | exmem_memwrite_i;

    // Next state and the freeze/advance decision for this cycle.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        freeze    = 1'b0;
        advance   = 1'b0;
        mem_req_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                mem_req_o = mem_access;
                if (mem_access && !mem_ack_i) begin
                    freeze  = 1'b1;
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = CNT_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    advance = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    freeze = 1'b1;
                    if (wcnt_q == MEM_TIMEOUT[CNT_W-1:0]) begin
                        state_d   = ST_ERROR;
                        timeout_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Load-use outranks a taken branch/jump; a frozen pipeline ignores both.
    always_comb begin
        pc_write_o     = advance && !load_use;
        ifid_write_o   = advance && !load_use;
        idex_write_o   = advance;
        exmem_write_o  = advance;
        idex_bubble_o  = advance && load_use;
        ifid_flush_o   = advance && !load_use && (branch_taken_i || jump_i);
        memwb_bubble_o = freeze;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((freeze || advance) && !pc_write_o) stall_cnt_d = sat_inc(stall_cnt_q);
        if (ifid_flush_o) flush_cnt_d = sat_inc(flush_cnt_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with a cycle-level behavioural model
// checked every cycle, plus hand-computed literal expectations.
module tb_pipeline_stall_ctrl;

    localparam int TMO  = 4;
    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_i, start_i;
    logic [5:0]    ifid_op_i;
    logic [4:0]    ifid_rs_i, ifid_rt_i, idex_rt_i;
    logic          idex_memread_i, branch_taken_i, jump_i;
    logic          exmem_memread_i, exmem_memwrite_i, mem_ack_i;
    logic          mem_req_o, pc_write_o, ifid_write_o, ifid_flush_o;
    logic          idex_write_o, idex_bubble_o, exmem_write_o, memwb_bubble_o;
    logic          mem_timeout_o;
    logic [PW-1:0] stall_cnt_o, flush_cnt_o;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8), .PERF_W(PW)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .ifid_op_i        (ifid_op_i),
        .ifid_rs_i        (ifid_rs_i),
        .ifid_rt_i        (ifid_rt_i),
        .idex_memread_i   (idex_memread_i),
        .idex_rt_i        (idex_rt_i),
        .branch_taken_i   (branch_taken_i),
        .jump_i           (jump_i),
        .exmem_memread_i  (exmem_memread_i),
        .exmem_memwrite_i (exmem_memwrite_i),
        .mem_ack_i        (mem_ack_i),
        .mem_req_o        (mem_req_o),
        .pc_write_o       (pc_write_o),
        .ifid_write_o     (ifid_write_o),
        .ifid_flush_o     (ifid_flush_o),
        .idex_write_o     (idex_write_o),
        .idex_bubble_o    (idex_bubble_o),
        .exmem_write_o    (exmem_write_o),
        .memwb_bubble_o   (memwb_bubble_o),
        .mem_timeout_o    (mem_timeout_o),
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: is the pipeline started, dead (timed out), how long has a memory
    // access been outstanding, and the counter values it should show.
    bit m_valid   = 1'b0;
    bit m_started = 1'b0;
    bit m_dead    = 1'b0;
    bit m_tmo     = 1'b0;
    int m_waited  = 0;
    int m_stall   = 0;
    int m_flush   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        bit ena, acc, frozen, adv, ut, lu;
        bit e_pc, e_fl;
        if (m_valid) begin
            chk("m_stall_cnt", 32'(stall_cnt_o), m_stall);
            chk("m_flush_cnt", 32'(flush_cnt_o), m_flush);
            chk("m_timeout", 32'(mem_timeout_o), 32'(m_tmo));
            ena    = m_started && !m_dead;
            acc    = exmem_memread_i || exmem_memwrite_i;
            frozen = ena && !mem_ack_i && (m_waited > 0 || acc);
            adv    = ena && !frozen;
            ut     = (ifid_op_i == 6'd0) || (ifid_op_i == 6'd4) || (ifid_op_i == 6'd43);
            lu     = idex_memread_i && (idex_rt_i != 0) &&
                     ((idex_rt_i == ifid_rs_i) || (ut && idex_rt_i == ifid_rt_i));
            e_pc   = adv && !lu;
            e_fl   = adv && !lu && (branch_taken_i || jump_i);
            chk("m_mem_req", 32'(mem_req_o), 32'(ena && (acc || m_waited > 0)));
            chk("m_pc_write", 32'(pc_write_o), 32'(e_pc));
            chk("m_ifid_write", 32'(ifid_write_o), 32'(e_pc));
            chk("m_ifid_flush", 32'(ifid_flush_o), 32'(e_fl));
            chk("m_idex_write", 32'(idex_write_o), 32'(adv));
            chk("m_idex_bubble", 32'(idex_bubble_o), 32'(adv && lu));
            chk("m_exmem_write", 32'(exmem_write_o), 32'(adv));
            chk("m_memwb_bubble", 32'(memwb_bubble_o), 32'(frozen));
            if (!rst_i) begin
                if (ena && !e_pc && m_stall < PMAX) m_stall++;
                if (e_fl && m_flush < PMAX) m_flush++;
                if (!m_started) m_started = start_i;
                else if (!m_dead) begin
                    if (frozen) begin
                        if (m_waited == TMO) begin
                            m_dead   = 1'b1;
                            m_tmo    = 1'b1;
                            m_waited = 0;
                        end else m_waited++;
                    end else m_waited = 0;
                end
            end
        end
        if (rst_i) begin
            m_valid   = 1'b1;
            m_started = 1'b0;
            m_dead    = 1'b0;
            m_tmo     = 1'b0;
            m_waited  = 0;
            m_stall   = 0;
            m_flush   = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ifid_op_i = 6'd0; ifid_rs_i = 5'd0; ifid_rt_i = 5'd0;
        idex_memread_i = 1'b0; idex_rt_i = 5'd0;
        branch_taken_i = 1'b0; jump_i = 1'b0;
        exmem_memread_i = 1'b0; exmem_memwrite_i = 1'b0; mem_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; step(); step(); rst_i = 1'b0;
    endtask

    task automatic go();
        start_i = 1'b1; step(); start_i = 1'b0;
    endtask

    task automatic set_lu(input logic [5:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] xrt);
        idex_memread_i = 1'b1; ifid_op_i = op; ifid_rs_i = rs;
        ifid_rt_i = rt; idex_rt_i = xrt;
    endtask

    typedef struct {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] xrt;
        logic       stall;
    } lu_vec_t;

    lu_vec_t lu_tab[6] = '{
        '{6'b000000, 5'd0, 5'd0, 5'd0, 1'b0},
        '{6'b001000, 5'd3, 5'd8, 5'd8, 1'b0},
        '{6'b100011, 5'd3, 5'd8, 5'd8, 1'b0},
        '{6'b001101, 5'd8, 5'd1, 5'd8, 1'b1},
        '{6'b101011, 5'd3, 5'd8, 5'd8, 1'b1},
        '{6'b000100, 5'd3, 5'd8, 5'd8, 1'b1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        clear_in();
        start_i = 1'b0;
        do_reset();

        // Reset/start
        start_i = 1'b1; exmem_memread_i = 1'b1; #1;
        chk("idle_pc_write", 32'(pc_write_o), 0);
        chk("idle_mem_req", 32'(mem_req_o), 0);
        step(); start_i = 1'b0; exmem_memread_i = 1'b0; #1;
        chk("run_pc_write", 32'(pc_write_o), 1);
        chk("reset_stall_cnt", 32'(stall_cnt_o), 0);
        chk("reset_flush_cnt", 32'(flush_cnt_o), 0);

        // Single load-use stall
        set_lu(6'b000000, 5'd3, 5'd8, 5'd8); #1;
        chk("lu_pc_write", 32'(pc_write_o), 0);
        chk("lu_idex_bubble", 32'(idex_bubble_o), 1);
        step(); clear_in(); #1;
        chk("lu_release_pc", 32'(pc_write_o), 1);
        step();
        chk("lu_stall_cnt", 32'(stall_cnt_o), 1);

        // Load-use qualification table
        foreach (lu_tab[i]) begin
            set_lu(lu_tab[i].op, lu_tab[i].rs, lu_tab[i].rt, lu_tab[i].xrt); #1;
            chk($sformatf("lu_tab%0d_pc", i), 32'(pc_write_o), 32'(!lu_tab[i].stall));
            step();
        end
        clear_in(); step();

        // Branch/jump flush and priority
        do_reset(); go();
        branch_taken_i = 1'b1; #1;
        chk("br_flush", 32'(ifid_flush_o), 1);
        step(); clear_in(); #1;
        chk("br_flush_cnt", 32'(flush_cnt_o), 1);
        branch_taken_i = 1'b1; set_lu(6'b000000, 5'd3, 5'd8, 5'd8); #1;
        chk("br_lu_flush", 32'(ifid_flush_o), 0);
        chk("br_lu_pc", 32'(pc_write_o), 0);
        step(); clear_in(); jump_i = 1'b1; #1;
        chk("j_flush", 32'(ifid_flush_o), 1);
        step(); clear_in();
        chk("j_flush_cnt", 32'(flush_cnt_o), 2);

        // Memory wait with late ack, then same-cycle ack
        do_reset(); go();
        exmem_memread_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mw%0d_memwb_bubble", k), 32'(memwb_bubble_o), 1);
            chk($sformatf("mw%0d_pc", k), 32'(pc_write_o), 0);
            step();
        end
        mem_ack_i = 1'b1; #1;
        chk("mw_ack_pc", 32'(pc_write_o), 1);
        chk("mw_ack_memwb", 32'(memwb_bubble_o), 0);
        chk("mw_ack_req", 32'(mem_req_o), 1);
        step(); clear_in();
        chk("mw_stall_cnt", 32'(stall_cnt_o), 3);
        exmem_memwrite_i = 1'b1; mem_ack_i = 1'b1; #1;
        chk("fast_ack_pc", 32'(pc_write_o), 1);
        step(); clear_in();
        chk("fast_ack_stall_cnt", 32'(stall_cnt_o), 3);
        exmem_memread_i = 1'b1; step();
        mem_ack_i = 1'b1; set_lu(6'b000000, 5'd8, 5'd1, 5'd8); #1;
        chk("ack_lu_bubble", 32'(idex_bubble_o), 1);
        step(); clear_in(); step();

        // Timeout into ERROR, then reset recovery
        do_reset(); go();
        exmem_memread_i = 1'b1;
        repeat (5) step();
        chk("err_timeout", 32'(mem_timeout_o), 1);
        chk("err_pc", 32'(pc_write_o), 0);
        chk("err_req", 32'(mem_req_o), 0);
        chk("err_stall_cnt", 32'(stall_cnt_o), 5);
        mem_ack_i = 1'b1;
        repeat (3) step();
        chk("err_ack_pc", 32'(pc_write_o), 0);
        chk("err_hold_stall", 32'(stall_cnt_o), 5);
        rst_i = 1'b1; step(); rst_i = 1'b0; #1;
        chk("err_rst_timeout", 32'(mem_timeout_o), 0);
        chk("err_rst_stall", 32'(stall_cnt_o), 0);
        clear_in(); go();
        exmem_memread_i = 1'b1; step(); step();
        rst_i = 1'b1; step(); rst_i = 1'b0; #1;
        chk("midwait_rst_req", 32'(mem_req_o), 0);
        chk("midwait_rst_pc", 32'(pc_write_o), 0);
        step(); clear_in();

        // Counter saturation
        go();
        set_lu(6'b000000, 5'd3, 5'd8, 5'd8);
        repeat (20) step();
        chk("stall_sat", 32'(stall_cnt_o), PMAX);
        clear_in(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
